// File: rtl/uart_rx.sv
// UART receiver. Samples an oversampled serial line, takes a 3-sample majority
// vote per bit, checks optional parity and the stop bit, and presents each good
// byte on P_DATA with a one-cycle data_valid pulse.

// Frame sequencer. The datapath reports counter events to it and decodes the
// one-hot state flags it returns.
module uart_rx_fsm (
  input  logic clk,
  input  logic rst,
  input  logic rx_low,    // line low while idle: start edge
  input  logic decide,    // majority decision point of the current bit
  input  logic bit_end,   // last edge of the current bit
  input  logic bit_val,   // majority-voted bit value, valid with decide
  input  logic last_bit,  // data bit 7 is in progress
  input  logic par_en,    // parity bit present (latched for the frame)
  output logic st_idle,
  output logic st_start,
  output logic st_data,
  output logic st_parity,
  output logic st_stop,
  output logic st_out
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, OUT} state_t;

  state_t current_state, next_state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) current_state <= IDLE;
    else     current_state <= next_state;
  end

  // Next-state logic. STOP leaves at the decision point, not at the bit end,
  // so a back-to-back start edge is never missed.
  always_comb begin
    next_state = current_state;
    case (current_state)
      IDLE:    if (rx_low) next_state = START;
      START:   begin
                 if (decide && bit_val) next_state = IDLE;
                 else if (bit_end)      next_state = DATA;
               end
      DATA:    if (bit_end && last_bit) next_state = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (decide)  next_state = OUT;
      OUT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign st_idle   = (current_state == IDLE);
  assign st_start  = (current_state == START);
  assign st_data   = (current_state == DATA);
  assign st_parity = (current_state == PARITY);
  assign st_stop   = (current_state == STOP);
  assign st_out    = (current_state == OUT);

endmodule

module uart_rx (
  input  logic       clk,
  input  logic       rst_n,     // active-high despite the name
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [5:0] prescale,
  output logic [7:0] P_DATA,
  output logic       par_err,
  output logic       stp_err,
  output logic       data_valid
);

  logic       st_idle, st_start, st_data, st_parity, st_stop, st_out;
  logic       active, rx_low, decide, bit_end, bit_val, last_bit;
  logic [5:0] edge_cnt, ps_q, half, ps_legal;
  logic [2:0] bit_cnt;
  logic [1:0] smp;
  logic [7:0] sr;
  logic       par_en_q, par_typ_q, exp_par;

  // Anything other than 16 or 32 runs at 8.
  assign ps_legal = (prescale == 6'd16 || prescale == 6'd32) ? prescale : 6'd8;

  assign active   = st_start | st_data | st_parity | st_stop;
  assign rx_low   = st_idle & ~RX_IN;
  assign half     = {1'b0, ps_q[5:1]};
  assign decide   = active && (edge_cnt == half);
  assign bit_end  = active && (edge_cnt == ps_q - 6'd1);
  assign last_bit = (bit_cnt == 3'd7);
  // Third vote is the live line value at the decision edge.
  assign bit_val  = (smp[0] & smp[1]) | (smp[0] & RX_IN) | (smp[1] & RX_IN);
  assign exp_par  = par_typ_q ? ~^sr : ^sr;

  uart_rx_fsm u_fsm (
    .clk      (clk),
    .rst      (rst_n),
    .rx_low   (rx_low),
    .decide   (decide),
    .bit_end  (bit_end),
    .bit_val  (bit_val),
    .last_bit (last_bit),
    .par_en   (par_en_q),
    .st_idle  (st_idle),
    .st_start (st_start),
    .st_data  (st_data),
    .st_parity(st_parity),
    .st_stop  (st_stop),
    .st_out   (st_out)
  );

  // Per-bit edge counter; held at 0 outside a frame so the start edge is count 0.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)        edge_cnt <= '0;
    else if (!active) edge_cnt <= '0;
    else if (bit_end) edge_cnt <= '0;
    else              edge_cnt <= edge_cnt + 6'd1;
  end

  // Frame configuration is frozen at the start edge; error flags clear there too.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ps_q      <= 6'd8;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (rx_low) begin
      ps_q      <= ps_legal;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  // Data bit index
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                  bit_cnt <= '0;
    else if (st_start)          bit_cnt <= '0;
    else if (st_data & bit_end) bit_cnt <= bit_cnt + 3'd1;
  end

  // First two majority samples, just before the decision edge
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) smp <= '0;
    else if (active) begin
      if (edge_cnt == half - 6'd2) smp[0] <= RX_IN;
      if (edge_cnt == half - 6'd1) smp[1] <= RX_IN;
    end
  end

  // LSB-first deserializer
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                 sr <= '0;
    else if (st_data & decide) sr <= {bit_val, sr[7:1]};
  end

  // Parity / stop checks, sticky until the next start edge
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      par_err <= 1'b0;
      stp_err <= 1'b0;
    end else if (rx_low) begin
      par_err <= 1'b0;
      stp_err <= 1'b0;
    end else begin
      if (st_parity & decide) par_err <= (bit_val != exp_par);
      if (st_stop & decide)   stp_err <= ~bit_val;
    end
  end

  // Publish a good byte; data_valid rises together with the new P_DATA.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      P_DATA     <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= st_out & ~par_err & ~stp_err;
      if (st_out & ~par_err & ~stp_err) P_DATA <= sr;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx. A frame-level model predicts the
// byte, error flags and pulse count of every frame from the serial rules.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic [7:0] P_DATA;
  logic       par_err, stp_err, data_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state
  int         pulses    = 0;
  int         long_puls = 0;
  logic       dv_prev   = 1'b0;
  logic [7:0] dv_data   = '0;

  // Model state
  logic [7:0] model_data = '0;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .prescale  (prescale),
    .P_DATA    (P_DATA),
    .par_err   (par_err),
    .stp_err   (stp_err),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      pulses++;
      dv_data = P_DATA;
      if (dv_prev) long_puls++;
    end
    dv_prev = data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; prescale port gets ps_in, bit time follows the legal value.
  task automatic send_frame(input logic [7:0] d, input int ps_in, input logic pen,
                            input logic ptyp, input logic par_flip, input logic stop_val);
    int   ps;
    logic pbit;
    ps       = (ps_in == 16 || ps_in == 32) ? ps_in : 8;
    prescale = ps_in[5:0];
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    RX_IN = 1'b0; tick(ps);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i]; tick(ps);
    end
    if (pen) begin
      pbit  = (ptyp ? ~^d : ^d) ^ par_flip;
      RX_IN = pbit; tick(ps);
    end
    if (stop_val) begin
      RX_IN = 1'b1; tick(ps);
    end else begin
      // Low across all three sample points, then back to idle.
      RX_IN = 1'b0; tick(ps / 2 + 1);
      RX_IN = 1'b1; tick(ps - ps / 2 - 1);
    end
  endtask

  // Send a frame and compare every observable against the model.
  task automatic frame_chk(input string tag, input logic [7:0] d, input int ps_in,
                           input logic pen, input logic ptyp, input logic par_flip,
                           input logic stop_val);
    int   p0;
    logic e_par, e_stp, ok;
    p0    = pulses;
    e_par = pen & par_flip;
    e_stp = ~stop_val;
    ok    = ~e_par & ~e_stp;
    if (ok) model_data = d;
    send_frame(d, ps_in, pen, ptyp, par_flip, stop_val);
    chk({tag, ".pulses"},  pulses - p0, ok ? 1 : 0);
    chk({tag, ".P_DATA"},  P_DATA,      model_data);
    chk({tag, ".par_err"}, par_err,     e_par);
    chk({tag, ".stp_err"}, stp_err,     e_stp);
    if (ok) chk({tag, ".dv_data"}, dv_data, d);
  endtask

  initial begin
    int         p0;
    int         ps_in;
    logic [7:0] d;
    logic       pen, ptyp;

    rst_n = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8;
    tick(3);
    chk("rst.P_DATA",     P_DATA,     8'h00);
    chk("rst.par_err",    par_err,    1'b0);
    chk("rst.stp_err",    stp_err,    1'b0);
    chk("rst.data_valid", data_valid, 1'b0);
    chk("rst.state_idle", int'(dut.u_fsm.current_state), 0);  // IDLE is the first enum item
    rst_n = 1'b0;
    tick(4);

    frame_chk("p8_A5",      8'hA5, 8,  1'b0, 1'b0, 1'b0, 1'b1);
    frame_chk("p16_odd",    8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1);
    frame_chk("p16_even",   8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
    frame_chk("p32_parbad", 8'h01, 32, 1'b1, 1'b0, 1'b1, 1'b1);
    frame_chk("stopbad",    8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    frame_chk("stop_par",   8'h77, 8,  1'b1, 1'b1, 1'b1, 1'b0);
    frame_chk("recover",    8'hC3, 8,  1'b1, 1'b1, 1'b0, 1'b1);
    frame_chk("illegal_ps", 8'h96, 20, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start glitch: one low clock, then a full high bit.
    p0 = pulses;
    prescale = 6'd8;
    RX_IN = 1'b0; tick(1);
    RX_IN = 1'b1; tick(8);
    chk("glitch.state_idle", int'(dut.u_fsm.current_state), 0);
    chk("glitch.pulses",     pulses - p0, 0);
    chk("glitch.P_DATA",     P_DATA,      model_data);
    chk("glitch.par_err",    par_err,     1'b0);
    chk("glitch.stp_err",    stp_err,     1'b0);
    frame_chk("after_glitch", 8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back random frames, no idle gap.
    for (int i = 0; i < 30; i++) begin
      ps_in = (i < 10) ? 8 : (i < 20) ? 16 : 32;
      d     = 8'($urandom);
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
      frame_chk($sformatf("rnd%0d", i), d, ps_in, pen, ptyp, 1'b0, 1'b1);
    end

    // Reset in the middle of a frame.
    p0 = pulses;
    prescale = 6'd16; PAR_EN = 1'b0;
    RX_IN = 1'b0; tick(16);
    RX_IN = 1'b1; tick(40);
    rst_n = 1'b1; tick(2);
    rst_n = 1'b0; RX_IN = 1'b1; tick(20);
    model_data = 8'h00;
    chk("midrst.pulses",     pulses - p0, 0);
    chk("midrst.P_DATA",     P_DATA,      model_data);
    chk("midrst.state_idle", int'(dut.u_fsm.current_state), 0);
    frame_chk("after_rst", 8'hE7, 16, 1'b1, 1'b0, 1'b0, 1'b1);

    chk("pulse_width", long_puls, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: UART_RX

Interface
REQ-001 SHALL have port clk, input, 1 bit: oversampling clock at prescale x bit rate; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-high reset (asserted when 1), despite the name.
REQ-003 SHALL have port RX_IN, input, 1 bit: serial line, idle high, LSB first.
REQ-004 SHALL have port PAR_EN, input, 1 bit: 1 = parity bit present between data and stop.
REQ-005 SHALL have port PAR_TYP, input, 1 bit: 1 = odd parity (bit = ~^data); 0 = even parity (bit = ^data).
REQ-006 SHALL have port prescale, input, 6 bits: clk cycles per bit; legal values 8, 16, 32.
REQ-007 SHALL have port P_DATA, output, 8 bits: last correctly received byte.
REQ-008 SHALL have port par_err, output, 1 bit: parity mismatch on the current/last frame.
REQ-009 SHALL have port stp_err, output, 1 bit: stop bit sampled low on the current/last frame.
REQ-010 SHALL have port data_valid, output, 1 bit: one-cycle pulse marking a new good byte on P_DATA.

Function
REQ-011 SHALL contain an FSM submodule instance named u_fsm with state register current_state and state constant IDLE; other sub-blocks (edge/bit counter, sampler, deserializer, parity/stop checkers) are free.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, OUT.
REQ-013 Frame format SHALL be: start(0), 8 data bits LSB first, optional parity, 1 stop(1).
REQ-014 In IDLE, RX_IN=0 on a clk edge SHALL move to START; edge counter = 0 on that edge.
REQ-015 Edge counter SHALL count 0..prescale-1 per bit, wrapping to 0 and advancing the bit phase at prescale-1.
REQ-016 Each bit SHALL be sampled at edge counts prescale/2-2, prescale/2-1, prescale/2; bit value = majority of the 3 samples.
REQ-017 START: sampled value 1 (glitch) SHALL return to IDLE at the sample decision, with no outputs changed; value 0 SHALL proceed to DATA at bit end.
REQ-018 DATA: 8 bits SHALL be shifted in LSB first; after bit 7 go to PARITY if PAR_EN=1, else STOP.
REQ-019 PARITY: par_err SHALL be set to (sampled bit != expected parity per PAR_TYP) at the sample decision; then STOP at bit end.
REQ-020 STOP: stp_err SHALL be set to (sampled bit == 0) at the sample decision; the FSM goes to OUT on the next edge without waiting for the stop-bit end.
REQ-021 OUT (one cycle): if par_err=0 and stp_err=0, P_DATA SHALL load the received byte and data_valid=1 for exactly that cycle; the FSM always returns to IDLE next.
REQ-022 A frame with any error SHALL leave P_DATA unchanged and assert no data_valid.
REQ-023 par_err and stp_err SHALL hold their values until cleared on the next START entry.
REQ-024 With PAR_EN=0, par_err SHALL stay 0.
REQ-025 PAR_EN, PAR_TYP and prescale SHALL be sampled on START entry and held for the frame.
REQ-026 Back-to-back frames SHALL work: a start edge arriving any time after OUT is accepted.
REQ-027 An illegal prescale (not 8/16/32) SHALL be handled as 8.

Reset
REQ-028 On rst_n=1 (asynchronous): FSM SHALL be in IDLE; counters, shift register, P_DATA=8'h00, par_err=0, stp_err=0, data_valid=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no data_valid; after release, the FSM waits for a new start edge.

Verification
REQ-030 prescale=8, PAR_EN=0, byte 8'hA5 -> after the stop-bit midpoint, data_valid pulses 1 cycle, P_DATA=8'hA5, par_err=0, stp_err=0.
REQ-031 prescale=16, PAR_EN=1, PAR_TYP=1, byte 8'h3C, parity bit 1 -> P_DATA=8'h3C, no errors; same with PAR_TYP=0 and parity bit 0 -> pass.
REQ-032 prescale=32, PAR_EN=1, PAR_TYP=0, byte 8'h01 with wrong parity bit 0 -> par_err=1, no data_valid, P_DATA unchanged.
REQ-033 Stop bit driven 0 -> stp_err=1, no data_valid.
REQ-034 RX_IN low for 1 clk, then high for a full bit -> current_state==IDLE, no outputs change.
REQ-035 30 random frames (10 each at prescale 8/16/32, random PAR_EN/PAR_TYP) sent back to back -> each P_DATA equals the sent byte with par_err=0, stp_err=0 at the end of its stop bit.
